// File: rtl/cmp.sv
// Registered two-operand comparator: EQ / NE / signed LT / unsigned LTU,
// result captured one cycle after the operands and op are presented.
module cmp #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_elemA,
    input  logic [DATA_WIDTH-1:0] i_elemB,
    input  logic [1:0]            i_op,
    output logic                  o_output
);

    localparam logic [1:0] OP_EQ  = 2'b00;
    localparam logic [1:0] OP_NE  = 2'b01;
    localparam logic [1:0] OP_LT  = 2'b10;
    localparam logic [1:0] OP_LTU = 2'b11;

    localparam int MSB = DATA_WIDTH - 1;

    logic isEqual;
    logic isLessUnsigned;
    logic isLessSigned;
    logic result_d;
    logic result_q;

    assign isEqual        = (i_elemA == i_elemB);
    assign isLessUnsigned = (i_elemA < i_elemB);

    // Differing sign bits decide the signed order outright; otherwise the
    // magnitude compare gives the right answer for both signs.
    assign isLessSigned = (i_elemA[MSB] != i_elemB[MSB]) ? i_elemA[MSB] : isLessUnsigned;

    always_comb begin
        result_d = 1'b0;
        case (i_op)
            OP_EQ:   result_d = isEqual;
            OP_NE:   result_d = !isEqual;
            OP_LT:   result_d = isLessSigned;
            OP_LTU:  result_d = isLessUnsigned;
            default: result_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= 1'b0;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_output = result_q;

endmodule

// File: tb/tb_cmp.sv
// Directed and short random checks of cmp at widths 8 and 32, run side by side
// on a shared clock and reset.
module tb_cmp;

    logic        clock = 1'b0;
    logic        resetN;
    logic [7:0]  elemA8;
    logic [7:0]  elemB8;
    logic [31:0] elemA32;
    logic [31:0] elemB32;
    logic [1:0]  op;
    logic        out8;
    logic        out32;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clock = ~clock;

    cmp #(.DATA_WIDTH(8)) dut8 (
        .i_clk    (clock),
        .i_rst_n  (resetN),
        .i_elemA  (elemA8),
        .i_elemB  (elemB8),
        .i_op     (op),
        .o_output (out8)
    );

    cmp #(.DATA_WIDTH(32)) dut32 (
        .i_clk    (clock),
        .i_rst_n  (resetN),
        .i_elemA  (elemA32),
        .i_elemB  (elemB32),
        .i_op     (op),
        .o_output (out32)
    );

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Drive both DUTs (narrow one sees the low byte) and step to just after the capturing edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        elemA8  = a[7:0];
        elemB8  = b[7:0];
        elemA32 = a;
        elemB32 = b;
        op      = o;
        @(posedge clock);
        #1;
    endtask

    function automatic logic model8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
        case (o)
            2'b00:   return a == b;
            2'b01:   return a != b;
            2'b10:   return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    function automatic logic model32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        case (o)
            2'b00:   return a == b;
            2'b01:   return a != b;
            2'b10:   return $signed(a) < $signed(b);
            default: return a < b;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  ro;
        logic        exp8;
        logic        exp32;

        // Held in reset with an input pattern that would otherwise yield 1.
        resetN  = 1'b0;
        elemA8  = 8'h05;
        elemB8  = 8'h05;
        elemA32 = 32'h5;
        elemB32 = 32'h5;
        op      = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("reset_hold_w8", out8, 1'b0);
            checkOutput("reset_hold_w32", out32, 1'b0);
        end
        #2 resetN = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("first_capture_w8", out8, 1'b1);
        checkOutput("first_capture_w32", out32, 1'b1);

        // Equal operands over all ops, with a pre-edge check that op changes wait for the clock.
        applyStimulus(32'h5, 32'h5, 2'b00);
        checkOutput("eq_eq_w8", out8, 1'b1);
        checkOutput("eq_eq_w32", out32, 1'b1);
        op = 2'b01;
        #2;
        checkOutput("eq_ne_before_edge_w8", out8, 1'b1);
        @(posedge clock);
        #1;
        checkOutput("eq_ne_w8", out8, 1'b0);
        checkOutput("eq_ne_w32", out32, 1'b0);
        applyStimulus(32'h5, 32'h5, 2'b10);
        checkOutput("eq_lt_w8", out8, 1'b0);
        checkOutput("eq_lt_w32", out32, 1'b0);
        applyStimulus(32'h5, 32'h5, 2'b11);
        checkOutput("eq_ltu_w8", out8, 1'b0);
        checkOutput("eq_ltu_w32", out32, 1'b0);

        // Equality boundaries at zero and all-ones.
        applyStimulus(32'h0, 32'h0, 2'b00);
        checkOutput("zero_eq_w8", out8, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
        checkOutput("ones_lt_w8", out8, 1'b0);
        checkOutput("ones_lt_w32", out32, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        checkOutput("ones_eq_w32", out32, 1'b1);

        // A < B, both positive.
        applyStimulus(32'h5, 32'h7, 2'b01);
        checkOutput("altb_ne_w8", out8, 1'b1);
        checkOutput("altb_ne_w32", out32, 1'b1);
        applyStimulus(32'h5, 32'h7, 2'b10);
        checkOutput("altb_lt_w8", out8, 1'b1);
        checkOutput("altb_lt_w32", out32, 1'b1);
        applyStimulus(32'h5, 32'h7, 2'b11);
        checkOutput("altb_ltu_w8", out8, 1'b1);
        checkOutput("altb_ltu_w32", out32, 1'b1);
        applyStimulus(32'h5, 32'h7, 2'b00);
        checkOutput("altb_eq_w8", out8, 1'b0);
        checkOutput("altb_eq_w32", out32, 1'b0);

        // Signed versus unsigned ordering at width 8.
        applyStimulus(32'h80, 32'h01, 2'b10);
        checkOutput("neg_vs_pos_lt_w8", out8, 1'b1);
        applyStimulus(32'h80, 32'h01, 2'b11);
        checkOutput("neg_vs_pos_ltu_w8", out8, 1'b0);
        applyStimulus(32'h80, 32'h7F, 2'b10);
        checkOutput("minneg_maxpos_lt_w8", out8, 1'b1);
        applyStimulus(32'h80, 32'h7F, 2'b11);
        checkOutput("minneg_maxpos_ltu_w8", out8, 1'b0);
        applyStimulus(32'h00, 32'hFF, 2'b10);
        checkOutput("zero_vs_ones_lt_w8", out8, 1'b0);
        applyStimulus(32'h00, 32'hFF, 2'b11);
        checkOutput("zero_vs_ones_ltu_w8", out8, 1'b1);

        // Most-negative vs most-positive at width 32; narrow DUT sees 0x00 vs 0xFF.
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 2'b10);
        checkOutput("minneg_maxpos_lt_w32", out32, 1'b1);
        checkOutput("low_zero_vs_ones_lt_w8", out8, 1'b0);
        applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 2'b11);
        checkOutput("minneg_maxpos_ltu_w32", out32, 1'b0);
        checkOutput("low_zero_vs_ones_ltu_w8", out8, 1'b1);

        // Back-to-back random vectors, a new one every cycle.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            ro = 2'($urandom_range(0, 3));
            exp8  = model8(ra[7:0], rb[7:0], ro);
            exp32 = model32(ra, rb, ro);
            applyStimulus(ra, rb, ro);
            checkOutput("random_w8", out8, exp8);
            checkOutput("random_w32", out32, exp32);
        end

        // Asynchronous reset mid-cycle clears the output before any edge.
        applyStimulus(32'h5, 32'h5, 2'b00);
        checkOutput("pre_async_w8", out8, 1'b1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_reset_w8", out8, 1'b0);
        checkOutput("async_reset_w32", out32, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("async_reset_hold_w8", out8, 1'b0);
        #2 resetN = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("post_async_w8", out8, 1'b1);
        checkOutput("post_async_w32", out32, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
